cache_fill_fsm: RTL

Miss-handling controller between the pipelined core's instruction/data caches and the multi-cycle main memory. On a cache miss it fetches the whole 16-byte block containing the missed address, one 16-bit word at a time. It streams each returned word into the cache data array, then writes the tag. While a fill is in flight it holds `fsm_busy` high, and the core uses that signal to stall the affected pipeline stage.

---
 rtl/cache_fill_fsm.sv | 108 ++++++++++
 1 files changed

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm
// Purpose  : Cache miss fill controller; fetches a whole block word by word
//            from main memory, streams it into the data array, then writes tag.
// Revision : 1.0  initial release
// ============================================================================
module cache_fill_fsm #(
  parameter int OFFSET_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_detected,
  input  logic [15:0]         miss_address,
  output logic                fsm_busy,
  output logic                mem_enable,
  output logic [15:0]         memory_address,
  input  logic                memory_data_valid,
  input  logic [15:0]         memory_data,
  output logic                write_data_array,
  output logic                write_tag_array,
  output logic [OFFSET_W-1:0] fill_word_offset,
  output logic [15:0]         fill_data
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [OFFSET_W:0] C_WORDS = {1'b1, {OFFSET_W{1'b0}}};
  localparam logic [OFFSET_W:0] C_LAST  = {1'b0, {OFFSET_W{1'b1}}};
  localparam logic [OFFSET_W:0] C_ONE   = {{OFFSET_W{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  // Only the block number is kept; the offset bits of the base are always zero.
  logic [14-OFFSET_W:0]  base_q, base_d;
  logic [OFFSET_W:0]     issue_cnt_q, issue_cnt_d;
  logic [OFFSET_W:0]     recv_cnt_q, recv_cnt_d;
  logic                  unused_miss_lsbs;

  assign unused_miss_lsbs = ^miss_address[OFFSET_W:0];
  assign fill_data        = memory_data;

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    fsm_busy         = 1'b0;
    mem_enable       = 1'b0;
    memory_address   = 16'h0000;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_word_offset = '0;

    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (miss_detected) begin
            fsm_busy       = 1'b1;
            mem_enable     = 1'b1;
            memory_address = {miss_address[15:OFFSET_W+1], {(OFFSET_W+1){1'b0}}};
            base_d         = miss_address[15:OFFSET_W+1];
            issue_cnt_d    = C_ONE;
            recv_cnt_d     = '0;
            state_d        = FILL;
          end
        end
        FILL: begin
          fsm_busy = 1'b1;
          // Word index replaces the offset field, so the tag bits never carry.
          if (issue_cnt_q < C_WORDS) begin
            mem_enable     = 1'b1;
            memory_address = {base_q, issue_cnt_q[OFFSET_W-1:0], 1'b0};
            issue_cnt_d    = issue_cnt_q + C_ONE;
          end
          if (memory_data_valid) begin
            write_data_array = 1'b1;
            fill_word_offset = recv_cnt_q[OFFSET_W-1:0];
            recv_cnt_d       = recv_cnt_q + C_ONE;
            if (recv_cnt_q == C_LAST) begin
              write_tag_array = 1'b1;
              state_d         = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

endmodule
`default_nettype wire
